// File: rtl/postfix_pkg.sv
// postfix_pkg: error codes, FSM states and ASCII operator codes shared by the postfix evaluator.
package postfix_pkg;
  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_DIVZERO   = 3'd3;
  localparam logic [2:0] ERR_BADOP     = 3'd4;
  localparam logic [2:0] ERR_MALFORMED = 3'd5;
  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  typedef enum logic [3:0] {
    ST_GET, ST_PUSH, ST_POP_B, ST_POP_A, ST_EXEC, ST_DIV, ST_WRITE, ST_DRAIN, ST_RESULT
  } state_t;
endpackage

// File: rtl/postfix_eval_if.sv
// postfix_eval_if: number/sign strobe streams in, result handshake out, of the postfix evaluator.
interface postfix_eval_if #(parameter int WIDTH = 16);
  logic [7:0] NUMBER_IN;
  logic NUMBER_STB;
  logic NUMBER_ACK;
  logic [7:0] SIGN_IN;
  logic SIGN_STB;
  logic SIGN_ACK;
  logic [WIDTH-1:0] RESULT;
  logic [2:0] ERROR;
  logic RESULT_STB;
  logic RESULT_ACK;
  logic BUSY;
  modport master (
    output NUMBER_IN, NUMBER_STB, SIGN_IN, SIGN_STB, RESULT_ACK,
    input NUMBER_ACK, SIGN_ACK, RESULT, ERROR, RESULT_STB, BUSY
  );
  modport slave (
    input NUMBER_IN, NUMBER_STB, SIGN_IN, SIGN_STB, RESULT_ACK,
    output NUMBER_ACK, SIGN_ACK, RESULT, ERROR, RESULT_STB, BUSY
  );
endinterface

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand store with single-cycle push/pop, occupancy count and full/empty flags.
module operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic CLK,
  input logic RST,
  input logic clr,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  assign ptr = count[AW-1:0];
  assign top = mem[ptr - AW'(1)];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) count <= '0;
    else if (clr) count <= '0;
    else if (push && !full) count <= count + CW'(1);
    else if (pop && !empty) count <= count - CW'(1);
  always_ff @(posedge CLK)
    if (push && !full) mem[ptr] <= din;
endmodule

// File: rtl/postfix_eval.sv
// postfix_eval: evaluates a postfix number/sign stream on an operand stack, one result per expression.
// POSTFIX_DIV_EN builds the iterative divider for '/'; without it '/' is rejected as BADOP.
module postfix_eval
  import postfix_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic CLK,
  input logic RST,
  postfix_eval_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef POSTFIX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [7:0] num_r, op_r;
  logic [WIDTH-1:0] a_r, b_r, acc, top, push_d, res_d, alu, div_q, result;
  logic [CW-1:0] count;
  logic [2:0] error, err_code;
  logic full, empty, push, pop, clr;
  logic num_ack, sign_ack, result_stb, num_ack_n, sign_ack_n;
  logic err_set, res_ld, lat_num, lat_op, done, stb_set, div_last;
  logic is_end, op_ok, underflow;
  assign bus.NUMBER_ACK = num_ack;
  assign bus.SIGN_ACK = sign_ack;
  assign bus.RESULT = result;
  assign bus.ERROR = error;
  assign bus.RESULT_STB = result_stb;
  assign bus.BUSY = state != ST_GET;
  assign is_end = bus.NUMBER_STB && bus.SIGN_STB;
  assign op_ok = bus.SIGN_IN == OP_ADD || bus.SIGN_IN == OP_SUB || bus.SIGN_IN == OP_MUL ||
                 (DIV_EN && bus.SIGN_IN == OP_DIV);
  assign underflow = empty || count == CW'(1);
  assign alu = op_r == OP_ADD ? a_r + b_r : op_r == OP_SUB ? a_r - b_r : a_r * b_r;
  assign push_d = state == ST_WRITE ? acc : WIDTH'(num_r);
  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) stack (
    .CLK, .RST, .clr, .push, .pop, .din(push_d), .top, .count, .full, .empty
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= ST_GET;
    else state <= state_n;
  always_comb begin
    state_n = state;
    num_ack_n = 1'b0;
    sign_ack_n = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    err_set = 1'b0;
    err_code = ERR_OK;
    res_ld = 1'b0;
    res_d = '0;
    lat_num = 1'b0;
    lat_op = 1'b0;
    done = 1'b0;
    stb_set = 1'b0;
    case (state)
      ST_GET:
        if (is_end) begin
          num_ack_n = 1'b1;
          sign_ack_n = 1'b1;
          res_ld = 1'b1;
          state_n = ST_RESULT;
          pop = count == CW'(1);
          res_d = pop ? top : '0;
          err_set = !pop;
          err_code = ERR_MALFORMED;
        end else if (bus.NUMBER_STB) begin
          num_ack_n = 1'b1;
          lat_num = !full;
          err_set = full;
          err_code = ERR_OVERFLOW;
          state_n = full ? ST_DRAIN : ST_PUSH;
        end else if (bus.SIGN_STB) begin
          sign_ack_n = 1'b1;
          lat_op = 1'b1;
          err_set = !op_ok || underflow;
          err_code = !op_ok ? ERR_BADOP : ERR_UNDERFLOW;
          state_n = err_set ? ST_DRAIN : ST_POP_B;
        end
      ST_PUSH: begin
        push = 1'b1;
        state_n = ST_GET;
      end
      ST_POP_B: begin
        pop = 1'b1;
        state_n = ST_POP_A;
      end
      ST_POP_A: begin
        pop = 1'b1;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        err_set = op_r == OP_DIV && b_r == '0;
        err_code = ERR_DIVZERO;
        state_n = op_r != OP_DIV ? ST_WRITE : err_set ? ST_DRAIN : ST_DIV;
      end
      ST_DIV: state_n = div_last ? ST_WRITE : ST_DIV;
      ST_WRITE: begin
        push = 1'b1;
        state_n = ST_GET;
      end
      // the previous item's strobe is still up while its ack is high, so skip that cycle
      ST_DRAIN:
        if (!num_ack && !sign_ack) begin
          num_ack_n = bus.NUMBER_STB;
          sign_ack_n = bus.SIGN_STB;
          res_ld = is_end;
          state_n = is_end ? ST_RESULT : ST_DRAIN;
        end
      ST_RESULT: begin
        stb_set = !result_stb;
        done = result_stb && bus.RESULT_ACK;
        clr = done;
        state_n = done ? ST_GET : ST_RESULT;
      end
      default: state_n = ST_GET;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      num_ack <= 1'b0;
      sign_ack <= 1'b0;
      result_stb <= 1'b0;
      result <= '0;
      error <= ERR_OK;
      num_r <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
    end else begin
      num_ack <= num_ack_n;
      sign_ack <= sign_ack_n;
      result_stb <= stb_set || (result_stb && !done);
      if (res_ld) result <= res_d;
      if (done) error <= ERR_OK;
      else if (err_set && error == ERR_OK) error <= err_code;
      if (lat_num) num_r <= bus.NUMBER_IN;
      if (lat_op) op_r <= bus.SIGN_IN;
      if (state == ST_POP_B) b_r <= top;
      if (state == ST_POP_A) a_r <= top;
      if (state == ST_EXEC) acc <= alu;
      if (div_last) acc <= div_q;
    end
`ifdef POSTFIX_DIV_EN
  // restoring divider on magnitudes; sign applied to the final quotient (truncation toward zero)
  localparam int NW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem, quo, dvs, q_n;
  logic [WIDTH:0] trial;
  logic [NW-1:0] cnt;
  logic neg, fit, div_go;
  assign trial = {rem, quo[WIDTH-1]};
  assign fit = trial >= {1'b0, dvs};
  assign q_n = {quo[WIDTH-2:0], fit};
  assign div_go = state == ST_EXEC && op_r == OP_DIV && b_r != '0;
  assign div_last = state == ST_DIV && cnt == NW'(WIDTH - 1);
  assign div_q = neg ? -q_n : q_n;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      neg <= 1'b0;
    end else if (div_go) begin
      rem <= '0;
      quo <= a_r[WIDTH-1] ? -a_r : a_r;
      dvs <= b_r[WIDTH-1] ? -b_r : b_r;
      cnt <= '0;
      neg <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
    end else if (state == ST_DIV) begin
      rem <= fit ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
      quo <= q_n;
      cnt <= cnt + NW'(1);
    end
`else
  assign div_last = 1'b0;
  assign div_q = '0;
`endif
endmodule

// File: doc/postfix_eval.md
# postfix_eval

Postfix evaluator: the consumer at the far end of the infix-to-postfix converter's output. It accepts the converter's number and sign strobe streams, evaluates the postfix expression on an internal operand stack, and presents one signed result, with an error code, per expression. It sits directly downstream of the converter and upstream of the result sink.

## Interface
- `WIDTH`, 16: arithmetic and result width in bits, minimum 9.
- `DEPTH`, 8: operand stack depth, power of two.
- `CLK` in, 1: single clock, rising edge.
- `RST` in, 1: reset, asynchronous, active-high.
- `NUMBER_IN` in, 8: unsigned operand.
- `NUMBER_STB` in, 1: operand valid; held until `NUMBER_ACK`.
- `NUMBER_ACK` out, 1: one-cycle accept pulse.
- `SIGN_IN` in, 8: ASCII operator `+`, `-`, `*` or `/`.
- `SIGN_STB` in, 1: operator valid; held until `SIGN_ACK`.
- `SIGN_ACK` out, 1: one-cycle accept pulse.
- `RESULT` out, WIDTH: signed two's-complement result.
- `ERROR` out, 3: error code, valid with `RESULT_STB`.
- `RESULT_STB` out, 1: result valid; held until `RESULT_ACK`.
- `RESULT_ACK` in, 1: result consumed.
- `BUSY` out, 1: high in any state other than GET.

## Operation
- `NUMBER_STB` and `SIGN_STB` high in the same cycle is the end-of-expression marker (END). Both ACKs pulse together.
- Operands are zero-extended to WIDTH. Results are two's complement modulo 2^WIDTH.
  - `*` keeps the low WIDTH bits of the product.
  - `/` is signed division truncated toward zero.
- For an operator, B is popped first, then A. The block computes A op B and pushes the result.
- FSM states: GET, PUSH, POP_B, POP_A, EXEC, DIV, WRITE, DRAIN, RESULT.
  - GET, number strobe: ACK, then PUSH, then GET.
  - GET, sign strobe: ACK, then POP_B, POP_A, EXEC (DIV for `/`), WRITE (push), then GET.
  - GET, END: if depth is exactly 1, pop into `RESULT` with `ERROR`=0 and go to RESULT. Otherwise go to RESULT with MALFORMED.
  - RESULT: hold `RESULT_STB`. On `RESULT_ACK`, clear the stack and `ERROR`, then go to GET.
- Error codes (from the package): 0 OK, 1 UNDERFLOW (operator with depth < 2), 2 OVERFLOW (push while full), 3 DIVZERO, 4 BADOP (unknown sign), 5 MALFORMED.
  - The first error is latched and later errors do not overwrite it.
  - The FSM then goes to DRAIN. DRAIN ACKs every input without evaluating it until END, then goes to RESULT with `RESULT`=0.
- Checks happen before any stack access: UNDERFLOW and BADOP are detected in GET, OVERFLOW in GET for numbers. The stack is never corrupted by a failing item.

## Timing
- ACKs are registered and fire one cycle after the strobe is sampled in GET (or DRAIN).
- Back-to-back numbers: one accepted every 2 cycles.
- `+`, `-`, `*`: 5 cycles from acceptance to the next accept.
- `/`: 5 + WIDTH cycles, using an iterative restoring divider (1 quotient bit per cycle in DIV). DIVZERO is flagged in EXEC without entering DIV.
- END to `RESULT_STB`: 2 cycles.
- Reset values: `NUMBER_ACK`=0, `SIGN_ACK`=0, `RESULT`=0, `ERROR`=0, `RESULT_STB`=0, `BUSY`=0. Stack depth is 0 and the FSM is in GET.
- Reset mid-operation (including mid-DIV or in RESULT) clears everything asynchronously. No partial result is emitted.
- Strobes arriving in the cycle reset deasserts are sampled on the next edge.

## Configuration
- `POSTFIX_DIV_EN` defined: `/` is evaluated through DIV as described above.
- `POSTFIX_DIV_EN` undefined: the divider is not built, and `/` raises BADOP in GET. All other timing is unchanged.

## Structure
- Package `postfix_pkg` holds:
  - the error code constants;
  - the FSM state enum;
  - the ASCII operator constants.
- Sub-module `operand_stack`, parameterised by WIDTH and DEPTH:
  - single-cycle push and pop;
  - `count`, `full` and `empty` outputs;
  - asynchronous clear from `RST`, synchronous clear input.

## Test plan
- 3, 4, `+`, END gives `RESULT`=7, `ERROR`=0. Check that each ACK is exactly one cycle wide.
- 2, 3, 4, `*`, `+`, END gives 14. 200, 200, `*`, END gives 0x9C40, `ERROR`=0.
- 5, 9, `-`, END gives 0xFFFC (-4). 9, 2, `/`, END gives 4 with `POSTFIX_DIV_EN`, BADOP without it.
- 7, 0, `/` gives DIVZERO, with remaining inputs drained. `+` as the first item gives UNDERFLOW. DEPTH+1 numbers give OVERFLOW. 1, 2, END gives MALFORMED.
- Hold `RESULT_ACK` low for 10 cycles: `RESULT_STB` and `RESULT` stay stable, and no inputs are ACKed.
- Assert `RST` in the middle of DIV: all outputs return to 0 immediately. The next expression 1, 1, `+`, END gives 2.
